operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 100 ++++++++++
 tb/tb_operand_fetch.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand fetch stage: scoreboarded RAW/WAW stall, register-bank read, one-entry output register.
// Define OPF_BYPASS_EN to forward a same-cycle writeback into the fetched operands.
module operand_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_rs1,
    input  logic [2:0]  in_rs2,
    input  logic        in_use1,
    input  logic        in_use2,
    input  logic [2:0]  in_rd,
    input  logic        in_rd_en,
    output logic [2:0]  rf_ra1,
    output logic [2:0]  rf_ra2,
    input  logic [15:0] rf_rd1,
    input  logic [15:0] rf_rd2,
    input  logic        wb_en,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_op1,
    output logic [15:0] out_op2,
    output logic [2:0]  out_rd,
    output logic        out_rd_en,
    input  logic        flush,
    output logic [15:0] stall_cnt
);

    logic [7:0]  pend;
    logic [7:0]  pend_next;
    logic        bypass1;
    logic        bypass2;
    logic        hazard;
    logic        accept;
    logic [15:0] op1_next;
    logic [15:0] op2_next;

    assign rf_ra1 = in_rs1;
    assign rf_ra2 = in_rs2;

`ifdef OPF_BYPASS_EN
    assign bypass1 = wb_en && (wb_addr == in_rs1);
    assign bypass2 = wb_en && (wb_addr == in_rs2);
`else
    assign bypass1 = 1'b0;
    assign bypass2 = 1'b0;
`endif

    // WAW term deliberately has no bypass: at most one write may be outstanding per register
    assign hazard = (in_use1 && pend[in_rs1] && !bypass1)
                 || (in_use2 && pend[in_rs2] && !bypass2)
                 || (in_rd_en && pend[in_rd]);

    assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    assign op1_next = bypass1 ? wb_data : rf_rd1;
    assign op2_next = bypass2 ? wb_data : rf_rd2;

    // set is applied after clear so an accept wins over a same-register writeback
    always_comb begin
        pend_next = pend;
        if (wb_en)
            pend_next[wb_addr] = 1'b0;
        if (accept && in_rd_en)
            pend_next[in_rd] = 1'b1;
        if (flush)
            pend_next = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_rd_en <= 1'b0;
            pend      <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_op1   <= op1_next;
                out_op2   <= op2_next;
                out_rd    <= in_rd;
                out_rd_en <= in_rd_en;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            pend <= pend_next;
            if (in_valid && hazard && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: vector table for single accepts, hand sequences for
// flush, RAW/WAW stalls, backpressure, async reset and stall counter saturation.
module tb_operand_fetch;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_rs1;
    logic [2:0]  in_rs2;
    logic        in_use1;
    logic        in_use2;
    logic [2:0]  in_rd;
    logic        in_rd_en;
    logic [2:0]  rf_ra1;
    logic [2:0]  rf_ra2;
    logic [15:0] rf_rd1;
    logic [15:0] rf_rd2;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_op1;
    logic [15:0] out_op2;
    logic [2:0]  out_rd;
    logic        out_rd_en;
    logic        flush;
    logic [15:0] stall_cnt;

    int unsigned n_pass;
    int unsigned n_total;
    logic [15:0] exp_stall;

    operand_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_use1   (in_use1),
        .in_use2   (in_use2),
        .in_rd     (in_rd),
        .in_rd_en  (in_rd_en),
        .rf_ra1    (rf_ra1),
        .rf_ra2    (rf_ra2),
        .rf_rd1    (rf_rd1),
        .rf_rd2    (rf_rd2),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op1   (out_op1),
        .out_op2   (out_op2),
        .out_rd    (out_rd),
        .out_rd_en (out_rd_en),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        use1;
        logic        use2;
        logic [2:0]  rd;
        logic        rd_en;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic        wb_en;
        logic [2:0]  wb_addr;
        logic [15:0] wb_data;
        logic [15:0] op1;
        logic [15:0] op2;
    } vec_t;

    vec_t vecs[5];

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
        chk16(name, {13'd0, act}, {13'd0, exp});
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk16(name, {15'd0, act}, {15'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] rs1, input logic [2:0] rs2, input logic use1,
                         input logic use2, input logic [2:0] rd, input logic rd_en);
        in_valid = 1'b1;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_use1  = use1;
        in_use2  = use2;
        in_rd    = rd;
        in_rd_en = rd_en;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_use1   = 1'b0;
        in_use2   = 1'b0;
        in_rd     = '0;
        in_rd_en  = 1'b0;
        rf_rd1    = '0;
        rf_rd2    = '0;
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        out_ready = 1'b1;
        flush     = 1'b0;

        vecs[0] = '{3'd2, 3'd3, 1'b1, 1'b1, 3'd1, 1'b0, 16'h1111, 16'h2222,
                    1'b0, 3'd0, 16'h0000, 16'h1111, 16'h2222};
        vecs[1] = '{3'd0, 3'd7, 1'b1, 1'b1, 3'd0, 1'b1, 16'hA5A5, 16'h5A5A,
                    1'b0, 3'd0, 16'h0000, 16'hA5A5, 16'h5A5A};
        vecs[2] = '{3'd1, 3'd2, 1'b1, 1'b0, 3'd3, 1'b0, 16'hFFFF, 16'h0001,
                    1'b0, 3'd0, 16'h0000, 16'hFFFF, 16'h0001};
        vecs[3] = '{3'd0, 3'd4, 1'b0, 1'b1, 3'd6, 1'b1, 16'h1234, 16'h8000,
                    1'b0, 3'd0, 16'h0000, 16'h1234, 16'h8000};
`ifdef OPF_BYPASS_EN
        vecs[4] = '{3'd5, 3'd5, 1'b1, 1'b1, 3'd2, 1'b0, 16'h0F0F, 16'hF0F0,
                    1'b1, 3'd5, 16'hCAFE, 16'hCAFE, 16'hCAFE};
`else
        vecs[4] = '{3'd5, 3'd5, 1'b1, 1'b1, 3'd2, 1'b0, 16'h0F0F, 16'hF0F0,
                    1'b1, 3'd5, 16'hCAFE, 16'h0F0F, 16'hF0F0};
`endif

        // reset state
        #1 reset = 1'b0;
        #1;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk16("rst_op1", out_op1, 16'h0000);
        chk16("rst_op2", out_op2, 16'h0000);
        chk3("rst_rd", out_rd, 3'd0);
        chk1("rst_rd_en", out_rd_en, 1'b0);
        chk16("rst_stall", stall_cnt, 16'h0000);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk1("rel_in_ready", in_ready, 1'b1);

        // back-to-back single accepts
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].use1, vecs[i].use2, vecs[i].rd, vecs[i].rd_en);
            rf_rd1  = vecs[i].rd1;
            rf_rd2  = vecs[i].rd2;
            wb_en   = vecs[i].wb_en;
            wb_addr = vecs[i].wb_addr;
            wb_data = vecs[i].wb_data;
            #1;
            chk1($sformatf("v%0d_in_ready", i), in_ready, 1'b1);
            chk3($sformatf("v%0d_ra1", i), rf_ra1, vecs[i].rs1);
            chk3($sformatf("v%0d_ra2", i), rf_ra2, vecs[i].rs2);
            tick();
            wb_en = 1'b0;
            chk1($sformatf("v%0d_out_valid", i), out_valid, 1'b1);
            chk16($sformatf("v%0d_op1", i), out_op1, vecs[i].op1);
            chk16($sformatf("v%0d_op2", i), out_op2, vecs[i].op2);
            chk3($sformatf("v%0d_rd", i), out_rd, vecs[i].rd);
            chk1($sformatf("v%0d_rd_en", i), out_rd_en, vecs[i].rd_en);
        end

        // flush with pend[0], pend[6] set and out_valid=1
        drive(3'd6, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
        #1;
        chk1("pre_flush_stall", in_ready, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk1("flush_out_valid", out_valid, 1'b0);
        rf_rd1 = 16'h6666;
        #1;
        chk1("post_flush_ready", in_ready, 1'b1);
        tick();
        chk1("post_flush_valid", out_valid, 1'b1);
        chk16("post_flush_op1", out_op1, 16'h6666);
        chk16("flush_stall_cnt", stall_cnt, 16'd1);

        // RAW stall on r5 until writeback
        drive(3'd0, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1);
        #1;
        chk1("raw_prod_ready", in_ready, 1'b1);
        tick();
        drive(3'd5, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
        rf_rd1 = 16'h0000;
        #1;
        chk1("raw_stall_ready", in_ready, 1'b0);
        tick();
        tick();
        chk16("raw_stall_cnt", stall_cnt, 16'd3);
        wb_en   = 1'b1;
        wb_addr = 3'd5;
        wb_data = 16'hBEEF;
        #1;
`ifdef OPF_BYPASS_EN
        chk1("raw_wb_ready", in_ready, 1'b1);
        tick();
        wb_en  = 1'b0;
        rf_rd1 = 16'hBEEF;
        exp_stall = 16'd3;
`else
        chk1("raw_wb_ready", in_ready, 1'b0);
        tick();
        wb_en  = 1'b0;
        rf_rd1 = 16'hBEEF;
        #1;
        chk1("raw_after_wb_ready", in_ready, 1'b1);
        tick();
        exp_stall = 16'd4;
`endif
        chk1("raw_out_valid", out_valid, 1'b1);
        chk16("raw_op1", out_op1, 16'hBEEF);
        chk16("raw_stall_final", stall_cnt, exp_stall);

        // backpressure: outputs hold for 3 cycles
        out_ready = 1'b0;
        drive(3'd1, 3'd2, 1'b1, 1'b1, 3'd7, 1'b0);
        rf_rd1 = 16'h1357;
        rf_rd2 = 16'h2468;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1($sformatf("bp%0d_in_ready", i), in_ready, 1'b0);
            tick();
            chk1($sformatf("bp%0d_valid", i), out_valid, 1'b1);
            chk16($sformatf("bp%0d_op1", i), out_op1, 16'hBEEF);
            chk3($sformatf("bp%0d_rd", i), out_rd, 3'd0);
        end
        out_ready = 1'b1;
        #1;
        chk1("bp_release_ready", in_ready, 1'b1);
        tick();
        chk16("bp_op1", out_op1, 16'h1357);
        chk16("bp_op2", out_op2, 16'h2468);
        chk3("bp_rd", out_rd, 3'd7);
        in_valid = 1'b0;
        tick();
        chk1("drain_valid", out_valid, 1'b0);
        chk16("bp_stall_cnt", stall_cnt, exp_stall);

        // set beats clear on r4, then WAW stall
        drive(3'd0, 3'd0, 1'b0, 1'b0, 3'd4, 1'b1);
        wb_en   = 1'b1;
        wb_addr = 3'd4;
        wb_data = 16'h0000;
        #1;
        chk1("waw_first_ready", in_ready, 1'b1);
        tick();
        wb_en = 1'b0;
        #1;
        chk1("waw_stall_ready", in_ready, 1'b0);
        tick();
        wb_en   = 1'b1;
        wb_addr = 3'd4;
        #1;
        chk1("waw_wb_cycle_ready", in_ready, 1'b0);
        tick();
        wb_en = 1'b0;
        #1;
        chk1("waw_clear_ready", in_ready, 1'b1);
        tick();
        chk3("waw_out_rd", out_rd, 3'd4);
        chk1("waw_out_rd_en", out_rd_en, 1'b1);
        exp_stall = exp_stall + 16'd2;
        chk16("waw_stall_cnt", stall_cnt, exp_stall);
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;

        // async reset mid-cycle with out_valid=1
        drive(3'd0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b0);
        rf_rd1 = 16'hABCD;
        tick();
        chk1("pre_areset_valid", out_valid, 1'b1);
        chk16("pre_areset_op1", out_op1, 16'hABCD);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk1("areset_valid", out_valid, 1'b0);
        chk16("areset_op1", out_op1, 16'h0000);
        chk16("areset_stall", stall_cnt, 16'h0000);
        tick();
        reset = 1'b1;
        #1;
        chk1("areset_rel_ready", in_ready, 1'b1);
        chk1("areset_rel_valid", out_valid, 1'b0);

        // stall counter saturation
        drive(3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1);
        tick();
        drive(3'd3, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
        repeat (65534) tick();
        chk16("sat_minus_one", stall_cnt, 16'hFFFE);
        repeat (6) tick();
        chk16("sat_stall", stall_cnt, 16'hFFFF);
        chk1("sat_in_ready", in_ready, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
